// File: rtl/adder_pkg.sv
// Shared constants and helpers for the parallel-prefix adder.
package adder_pkg;

   // Default operand/sum width.
   localparam int ADDER_W = 25;

   // Number of Kogge-Stone prefix levels needed to span n bits: ceil(log2(n)).
   function automatic int prefix_levels(input int n);
      int lv;
      lv = 0;
      for (int k = 0; k < 7; k++) begin
         if ((32'sd1 <<< k) < n) begin
            lv = k + 1;
         end else begin
            lv = lv;
         end
      end
      return lv;
   endfunction

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone black cell: merges a high (G,P) group with the adjacent low group.
module prefix_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);

   // Group generate/propagate merge.
   always_comb begin
      g = g_hi | (p_hi & g_lo);
      p = p_hi & p_lo;
   end

endmodule

// File: rtl/prefix_adder.sv
// N-bit unsigned adder built on a Kogge-Stone prefix carry network,
// with sum and carry-out registered (one cycle latency, full throughput).
module prefix_adder
   import adder_pkg::*;
#(
   parameter int N = ADDER_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] input1,
   input  logic [N-1:0] input2,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int LEVELS = prefix_levels(N);

   // Stage s holds the (G,P) of each bit after s prefix levels; stage 0 is bitwise.
   logic [LEVELS:0][N-1:0] g_st;
   logic [LEVELS:0][N-1:0] p_st;
   // The final group propagate is not needed by the sum or carry-out.
   logic [N-1:0]           p_final_unused_s;

   logic [N-1:0] sum_d;
   logic [N-1:0] sum_q;
   logic         cout_d;
   logic         cout_q;

   assign g_st[0]          = input1 & input2;
   assign p_st[0]          = input1 ^ input2;
   assign p_final_unused_s = p_st[LEVELS];

   // Prefix network: at level lv, bit i merges with bit i - 2^lv; low bits pass through.
   for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
      localparam int DIST = 1 << lv;
      for (genvar i = 0; i < N; i++) begin : g_bit
         if (i >= DIST) begin : g_black
            prefix_cell u_cell (
               .g_hi (g_st[lv][i]),
               .p_hi (p_st[lv][i]),
               .g_lo (g_st[lv][i-DIST]),
               .p_lo (p_st[lv][i-DIST]),
               .g    (g_st[lv+1][i]),
               .p    (p_st[lv+1][i])
            );
         end else begin : g_pass
            assign g_st[lv+1][i] = g_st[lv][i];
            assign p_st[lv+1][i] = p_st[lv][i];
         end
      end
   end

   // Sum bit i is its propagate XOR the carry into it (group generate of bits i-1..0).
   always_comb begin
      sum_d  = p_st[0] ^ {g_st[LEVELS][N-2:0], 1'b0};
      cout_d = g_st[LEVELS][N-1];
   end

   // Output register, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= {N{1'b0}};
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_prefix_adder.sv
// Scoreboard testbench for prefix_adder: stimulus pushes exact (N+1)-bit sums,
// a negedge monitor pops and compares against the registered outputs.
module tb_prefix_adder;

   localparam int W = 25;
   localparam logic [W-1:0] MAXV = {W{1'b1}};

   logic         clk;
   logic         rst_n;
   logic [W-1:0] input1;
   logic [W-1:0] input2;
   logic [W-1:0] sum;
   logic         cout;

   int checks   = 0;
   int failures = 0;

   logic [W:0] exp_q[$];

   logic idle_watch = 1'b0;
   int   toggles    = 0;

   prefix_adder #(.N(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .input1 (input1),
      .input2 (input2),
      .sum    (sum),
      .cout   (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact unsigned sum with one extra bit.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Apply one operand pair just after a falling edge and record the expected result.
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      #1;
      input1 = a;
      input2 = b;
      exp_q.push_back(ref_add(a, b));
   endtask

   // Wait (bounded) until every pushed expectation has been compared.
   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("drain", {1'b0, 25'(exp_q.size())}, {1'b0, 25'd0});
   endtask

   // Monitor: compare the registered outputs with the oldest expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W:0] e;
         e = exp_q.pop_front();
         checks++;
         if ({cout, sum} !== e) begin
            failures++;
            $display("FAIL sb_result got=%h exp=%h", {cout, sum}, e);
         end
      end
   end

   // Output activity counter used for the idle-hold check.
   always @(sum or cout) begin
      if (idle_watch) toggles++;
   end

   initial begin
      rst_n  = 1'b1;
      input1 = 25'h0000005;
      input2 = 25'h0000007;
      #1 rst_n = 1'b0;
      #2;
      check("reset_async", {cout, sum}, 26'h0);
      // Clock edges during reset keep the outputs at zero.
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", {cout, sum}, 26'h0);

      // Release and resume.
      @(negedge clk);
      #1;
      input1 = 25'h0000000;
      input2 = 25'h0000000;
      rst_n  = 1'b1;
      exp_q.push_back(26'h0);

      // Directed burst (back-to-back, single-cycle latency).
      drive(25'h0000000, 25'h1FFFF80);
      drive(25'h1FFC000, 25'h1FFFFFF);
      drive(25'h1FFFFFF, 25'h0000001);
      drive(MAXV, MAXV);
      drain();
      check("max_plus_max", {cout, sum}, 26'h3FFFFFE);

      // Mid-stream reset: the operands loaded now must never appear.
      #1;
      input1 = 25'h0000123;
      input2 = 25'h0000456;
      #1 rst_n = 1'b0;
      #1;
      check("midreset_async", {cout, sum}, 26'h0);
      @(posedge clk);
      #1;
      check("midreset_discard", {cout, sum}, 26'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back(ref_add(input1, input2));
      drain();

      // Idle hold: constant operands, no output activity after the first capture.
      drive(25'h0000003, 25'h0000000);
      @(posedge clk);
      #1;
      toggles    = 0;
      idle_watch = 1'b1;
      repeat (6) drive(25'h0000003, 25'h0000000);
      @(posedge clk);
      #1;
      idle_watch = 1'b0;
      check("idle_toggles", {1'b0, 25'(toggles)}, 26'h0);
      check("idle_value", {cout, sum}, 26'h0000003);
      drain();

      // Random regression with carry-chain-biased patterns.
      for (int k = 0; k < 10000; k++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom());
         b = W'($urandom());
         case ($urandom_range(0, 4))
            0: a = MAXV;
            1: b = ~a;
            2: b = ~a + W'(1);
            3: b = W'(1) << $urandom_range(0, W - 1);
            default: b = b;
         endcase
         drive(a, b);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
